// File: rtl/fht_seq_param.sv
// Stage sequencer for a four-bank radix-2 FHT with run-time length and parametrised write latency.
// Defining FHT_ABORT_EN adds the iABORT input and oABORTED pulse output.
module fht_seq_param #(
    parameter int A_BIT   = 8,
    parameter int LEN_BIT = 4,
    parameter int WR_LAT  = 3,
    parameter int SEC_BIT = 9
) (
    input  logic               iCLK,
    input  logic               iRESET,
    input  logic               iSTART,
    input  logic [LEN_BIT-1:0] iLEN_LOG2,
`ifdef FHT_ABORT_EN
    input  logic               iABORT,
    output logic               oABORTED,
`endif
    output logic               oBUSY,
    output logic               oRDY,
    output logic               oDONE,
    output logic [LEN_BIT-1:0] oSTAGE,
    output logic               oST_ZERO,
    output logic               oST_LAST,
    output logic               o2ND_PART_SUBSEC,
    output logic [SEC_BIT-1:0] oSECTOR,
    output logic [A_BIT-1:0]   oADDR_RD_0,
    output logic [A_BIT-1:0]   oADDR_RD_1,
    output logic [A_BIT-1:0]   oADDR_RD_2,
    output logic [A_BIT-1:0]   oADDR_RD_3,
    output logic [A_BIT-1:0]   oADDR_WR_0,
    output logic [A_BIT-1:0]   oADDR_WR_1,
    output logic [A_BIT-1:0]   oADDR_WR_2,
    output logic [A_BIT-1:0]   oADDR_WR_3,
    output logic [A_BIT-1:0]   oADDR_COEF,
    output logic               oWE_A,
    output logic               oWE_B,
    output logic               oSOURCE_DATA,
    output logic               oSOURCE_CONT
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_FLUSH, S_DONE} state_t;

    // stage-time counter spans L read cycles plus up to 7 flush cycles
    localparam int CW = $clog2((1 << A_BIT) + 8);

    state_t                       r_state, w_next;
    logic [LEN_BIT-1:0]           r_len, r_stage, w_len_clamp, w_dlog;
    logic [CW-1:0]                r_cnt, w_L;
    logic [A_BIT-1:0]             w_cnt, w_mask, w_half, w_off, w_base, w_rd_x, w_sec_a;
    logic [A_BIT-1:0]             w_cnt_d, w_wr_lo, w_wr_hi, r_coef;
    logic [WR_LAT-1:0][A_BIT-1:0] r_cnt_pipe;
    logic [WR_LAT-1:0]            r_vld_pipe;
    logic                         r_src, r_cont, w_busy, w_mid, w_read_end, w_stage_end;
    logic                         w_last, w_abort, w_we, w_d_first;

    function automatic logic [A_BIT-1:0] f_bitrev(input logic [A_BIT-1:0] v);
        logic [A_BIT-1:0] r;
        for (int i = 0; i < A_BIT; i++) r[A_BIT-1-i] = v[i];
        return r;
    endfunction

`ifdef FHT_ABORT_EN
    logic r_aborted;
    assign w_abort  = iABORT && w_busy;
    assign oABORTED = r_aborted;
    always_ff @(posedge iCLK) begin
        if (!iRESET) r_aborted <= 1'b0;
        else         r_aborted <= w_abort;
    end
`else
    assign w_abort = 1'b0;
`endif

    always_comb begin
        w_len_clamp = iLEN_LOG2;
        if (iLEN_LOG2 < LEN_BIT'(2))          w_len_clamp = LEN_BIT'(2);
        else if (iLEN_LOG2 > LEN_BIT'(A_BIT)) w_len_clamp = LEN_BIT'(A_BIT);
    end

    assign w_L         = CW'(1) << r_len;
    assign w_read_end  = (r_cnt == w_L - CW'(1));
    assign w_stage_end = (r_cnt == w_L + CW'(WR_LAT - 1));
    assign w_last      = (r_stage == r_len + LEN_BIT'(1));
    assign w_busy      = (r_state == S_READ) || (r_state == S_FLUSH);
    assign w_mid       = w_busy && (r_stage != '0) && (r_stage <= r_len);

    // subsector size D = 2^w_dlog; direct stages span the whole bank
    assign w_dlog  = w_mid ? (r_len - r_stage + LEN_BIT'(1)) : r_len;
    assign w_mask  = ~({A_BIT{1'b1}} << w_dlog);
    assign w_half  = w_mid ? (A_BIT'(1) << (w_dlog - LEN_BIT'(1))) : '0;

    assign w_cnt   = (r_state == S_READ) ? r_cnt[A_BIT-1:0] : '0;
    assign w_off   = w_cnt & w_mask;
    assign w_base  = w_cnt & ~w_mask;
    assign w_rd_x  = w_mid ? (w_base + ((A_BIT'(0) - w_off) & w_mask)) : w_cnt;
    assign w_sec_a = w_cnt >> w_dlog;

    assign w_cnt_d   = r_cnt_pipe[WR_LAT-1];
    assign w_we      = r_vld_pipe[WR_LAT-1];
    assign w_d_first = ((w_cnt_d & w_half) == '0);
    assign w_wr_lo   = (w_mid && !w_d_first) ? (w_cnt_d - w_half) : w_cnt_d;
    assign w_wr_hi   = (w_mid &&  w_d_first) ? (w_cnt_d + w_half) : w_cnt_d;

    always_ff @(posedge iCLK) begin
        if (!iRESET) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (iSTART) w_next = S_READ;
            S_READ:  if (w_abort) w_next = S_IDLE;
                     else if (w_read_end) w_next = S_FLUSH;
            S_FLUSH: if (w_abort) w_next = S_IDLE;
                     else if (w_stage_end) w_next = w_last ? S_DONE : S_READ;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        oBUSY = w_busy;
        oRDY  = !w_busy;
        oDONE = (r_state == S_DONE);
    end

    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            r_len      <= '0;
            r_stage    <= '0;
            r_cnt      <= '0;
            r_src      <= 1'b0;
            r_cont     <= 1'b1;
            r_coef     <= '0;
            r_cnt_pipe <= '0;
            r_vld_pipe <= '0;
        end else begin
            r_cont        <= !w_busy;
            r_coef        <= w_mid ? f_bitrev(w_sec_a) : '0;
            r_cnt_pipe[0] <= w_cnt;
            r_vld_pipe[0] <= (r_state == S_READ);
            for (int i = 1; i < WR_LAT; i++) begin
                r_cnt_pipe[i] <= r_cnt_pipe[i-1];
                r_vld_pipe[i] <= r_vld_pipe[i-1];
            end
            case (r_state)
                S_IDLE: if (iSTART) begin
                    r_len   <= w_len_clamp;
                    r_stage <= '0;
                    r_cnt   <= '0;
                end
                S_READ: r_cnt <= r_cnt + CW'(1);
                S_FLUSH: if (w_stage_end) begin
                    r_cnt <= '0;
                    if (!w_last) begin
                        r_stage <= r_stage + LEN_BIT'(1);
                        r_src   <= !r_src;
                    end
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
                default: r_cnt <= '0;
            endcase
            // abort kills in-flight writes on the same edge
            if (w_abort) begin
                r_cnt      <= '0;
                r_vld_pipe <= '0;
            end
        end
    end

    assign oSTAGE           = r_stage;
    assign oST_ZERO         = w_busy && (r_stage == '0);
    assign oST_LAST         = w_busy && w_last;
    assign o2ND_PART_SUBSEC = w_mid && ((w_off & w_half) != '0);
    assign oSECTOR          = SEC_BIT'(w_sec_a);
    assign oADDR_RD_0       = w_cnt;
    assign oADDR_RD_2       = w_cnt;
    assign oADDR_RD_1       = w_rd_x;
    assign oADDR_RD_3       = w_rd_x;
    assign oADDR_WR_0       = w_wr_lo;
    assign oADDR_WR_1       = w_wr_lo;
    assign oADDR_WR_2       = w_wr_hi;
    assign oADDR_WR_3       = w_wr_hi;
    assign oADDR_COEF       = r_coef;
    assign oWE_A            = w_we &&  r_stage[0];
    assign oWE_B            = w_we && !r_stage[0];
    assign oSOURCE_DATA     = r_src;
    assign oSOURCE_CONT     = r_cont;

endmodule

// File: tb/tb_fht_seq_param.sv
// Bench for fht_seq_param: table of lengths plus random runs against a per-cycle arithmetic model.
module tb_fht_seq_param;
  localparam int A_BIT = 8, LEN_BIT = 4, WR_LAT = 3, SEC_BIT = 9;

  logic iCLK = 1'b0, iRESET = 1'b0, iSTART = 1'b0;
  logic [LEN_BIT-1:0] iLEN_LOG2 = '0;
`ifdef FHT_ABORT_EN
  logic iABORT = 1'b0;
  logic oABORTED;
`endif
  logic oBUSY, oRDY, oDONE, oST_ZERO, oST_LAST, o2ND_PART_SUBSEC;
  logic [LEN_BIT-1:0] oSTAGE;
  logic [SEC_BIT-1:0] oSECTOR;
  logic [A_BIT-1:0] oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3;
  logic [A_BIT-1:0] oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3, oADDR_COEF;
  logic oWE_A, oWE_B, oSOURCE_DATA, oSOURCE_CONT;

  fht_seq_param #(.A_BIT(A_BIT), .LEN_BIT(LEN_BIT), .WR_LAT(WR_LAT), .SEC_BIT(SEC_BIT)) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iSTART(iSTART), .iLEN_LOG2(iLEN_LOG2),
`ifdef FHT_ABORT_EN
    .iABORT(iABORT), .oABORTED(oABORTED),
`endif
    .oBUSY(oBUSY), .oRDY(oRDY), .oDONE(oDONE), .oSTAGE(oSTAGE), .oST_ZERO(oST_ZERO),
    .oST_LAST(oST_LAST), .o2ND_PART_SUBSEC(o2ND_PART_SUBSEC), .oSECTOR(oSECTOR),
    .oADDR_RD_0(oADDR_RD_0), .oADDR_RD_1(oADDR_RD_1), .oADDR_RD_2(oADDR_RD_2), .oADDR_RD_3(oADDR_RD_3),
    .oADDR_WR_0(oADDR_WR_0), .oADDR_WR_1(oADDR_WR_1), .oADDR_WR_2(oADDR_WR_2), .oADDR_WR_3(oADDR_WR_3),
    .oADDR_COEF(oADDR_COEF), .oWE_A(oWE_A), .oWE_B(oWE_B),
    .oSOURCE_DATA(oSOURCE_DATA), .oSOURCE_CONT(oSOURCE_CONT));

  always #5 iCLK = ~iCLK;

  wire [94:0] w_act = {oBUSY, oRDY, oDONE, oSTAGE, oST_ZERO, oST_LAST, o2ND_PART_SUBSEC, oSECTOR,
                       oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3,
                       oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3,
                       oADDR_COEF, oWE_A, oWE_B, oSOURCE_DATA, oSOURCE_CONT};

  int checks = 0, errors = 0;
  bit exp_sd = 1'b0;

  typedef struct { int len_in; bit hold; int exp_busy; int exp_stages; } vec_t;

  function automatic int clamp(input int v);
    return (v < 2) ? 2 : ((v > A_BIT) ? A_BIT : v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chkv(input string name, input logic [94:0] act, input logic [94:0] exp, input logic [94:0] m);
    checks++;
    if (((act ^ exp) & m) !== 95'd0) begin
      errors++;
      $display("FAIL %s: got %h expected %h mask %h", name, act, exp, m);
    end
  endtask

  // Expected outputs t cycles after the first READ cycle, derived from stage period arithmetic.
  task automatic check_cycle(input int len_c, input int t);
    int L, P, S, stg, k, kw, D, h, rd, w01, w23;
    bit mid, sd_end;
    logic [94:0] e, m;
    logic [7:0] sv, cf;
    L = 1 << len_c; P = L + WR_LAT; S = len_c + 2;
    sd_end = exp_sd ^ (((S - 1) % 2) == 1);
    e = '0; m = '0;
    if (t < S * P) begin
      stg = t / P; k = t % P; mid = (stg >= 1 && stg <= len_c);
      D = mid ? (L >> (stg - 1)) : L; h = D / 2;
      e[94] = 1'b1; e[91:88] = 4'(stg); e[87] = (stg == 0); e[86] = (stg == S - 1);
      e[1] = exp_sd ^ (stg % 2 == 1); e[0] = (t == 0);
      m[94:86] = '1; m[3:0] = '1;
      if (k < L) begin
        rd = mid ? ((k / D) * D + ((D - (k % D)) % D)) : k;
        e[85] = mid && ((k % D) >= h); e[84:76] = 9'(k / D);
        e[75:68] = 8'(k); e[67:60] = 8'(rd); e[59:52] = 8'(k); e[51:44] = 8'(rd);
        m[85:44] = '1;
      end
      kw = k - WR_LAT;
      if (kw >= 0 && kw < L) begin
        e[3] = (stg % 2 == 1); e[2] = (stg % 2 == 0);
        if (!mid)            begin w01 = kw;     w23 = kw;     end
        else if (kw % D < h) begin w01 = kw;     w23 = kw + h; end
        else                 begin w01 = kw - h; w23 = kw;     end
        e[43:36] = 8'(w01); e[35:28] = 8'(w01); e[27:20] = 8'(w23); e[19:12] = 8'(w23);
        m[43:12] = '1;
      end
      if (t == 0) m[11:4] = '1;
      else if (k >= 1 && k - 1 < L) begin
        sv = 8'((k - 1) / D);
        for (int i = 0; i < 8; i++) cf[7-i] = sv[i];
        e[11:4] = mid ? cf : 8'd0; m[11:4] = '1;
      end
    end else if (t == S * P) begin
      e[93] = 1'b1; e[92] = 1'b1; e[91:88] = 4'(S - 1); e[1] = sd_end;
      m[94:86] = '1; m[3:0] = '1;
    end else begin
      e[93] = 1'b1; e[1] = sd_end; e[0] = 1'b1;
      m[94:92] = '1; m[3:0] = '1;
    end
    chkv($sformatf("cyc_len%0d_t%0d", len_c, t), w_act, e, m);
  endtask

  task automatic spot(input int t);
    case (t)
      9:           chk("s0_rd1_c9", int'(oADDR_RD_1), 9);
      10:          chk("s0_coef", int'(oADDR_COEF), 0);
      2*259:       chk("s2_rd1_c0", int'(oADDR_RD_1), 0);
      2*259+5:     chk("s2_rd1_c5", int'(oADDR_RD_1), 123);
      2*259+130:   chk("s2_rd1_c130", int'(oADDR_RD_1), 254);
      2*259+13:    begin chk("s2_wr0_d10", int'(oADDR_WR_0), 10); chk("s2_wr2_d10", int'(oADDR_WR_2), 74); end
      2*259+73:    begin chk("s2_wr0_d70", int'(oADDR_WR_0), 6);  chk("s2_wr2_d70", int'(oADDR_WR_2), 70); end
      3*259+130:   chk("s3_sector", int'(oSECTOR), 2);
      3*259+131:   chk("s3_coef", int'(oADDR_COEF), 64);
      9*259+7:     chk("s9_rd1_c7", int'(oADDR_RD_1), 7);
      9*259+8:     chk("s9_coef", int'(oADDR_COEF), 0);
      default: ;
    endcase
  endtask

  // Called at a negedge in IDLE; returns at a negedge in IDLE (or at stop_at, mid-run).
  task automatic run(input int len_in, input bit hold, input int stop_at,
                     output int busy_n, output int done_n, output int tog_n);
    int len_c, total;
    bit prev;
    len_c = clamp(len_in);
    total = (len_c + 2) * ((1 << len_c) + WR_LAT);
    busy_n = 0; done_n = 0; tog_n = 0;
    iLEN_LOG2 = 4'(len_in); iSTART = 1'b1;
    @(negedge iCLK);
    if (!hold) iSTART = 1'b0;
    prev = oSOURCE_DATA;
    for (int t = 0; t <= total + 1; t++) begin
      if (t == stop_at) break;
      check_cycle(len_c, t);
      if (len_c == 8) spot(t);
      busy_n += int'(oBUSY); done_n += int'(oDONE);
      if (oSOURCE_DATA != prev) tog_n++;
      prev = oSOURCE_DATA;
      if (t == total - 1) iSTART = 1'b0;
      @(negedge iCLK);
    end
    if (stop_at < 0) exp_sd = exp_sd ^ (((len_c + 1) % 2) == 1);
  endtask

  initial begin
    vec_t vt[6];
    int b, d, tg, li, lc, dn;
    bit hd;
    logic [94:0] e;
    vt[0] = '{8,  1'b0, 2590, 10};
    vt[1] = '{4,  1'b1, 114,  6};
    vt[2] = '{15, 1'b0, 2590, 10};
    vt[3] = '{0,  1'b0, 28,   4};
    vt[4] = '{2,  1'b1, 28,   4};
    vt[5] = '{5,  1'b0, 245,  7};

    repeat (3) @(negedge iCLK);
    e = '0; e[93] = 1'b1; e[0] = 1'b1;
    chkv("reset_state", w_act, e, '1);
    iRESET = 1'b1;
    @(negedge iCLK);

    for (int i = 0; i < 6; i++) begin
      run(vt[i].len_in, vt[i].hold, -1, b, d, tg);
      chk($sformatf("busy_cycles_len%0d", vt[i].len_in), b, vt[i].exp_busy);
      chk($sformatf("done_pulses_len%0d", vt[i].len_in), d, 1);
      chk($sformatf("src_toggles_len%0d", vt[i].len_in), tg, vt[i].exp_stages - 1);
      @(negedge iCLK);
    end

    for (int r = 0; r < 3; r++) begin
      li = int'($urandom_range(0, 15));
      hd = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 4)) @(negedge iCLK);
      run(li, hd, -1, b, d, tg);
      lc = clamp(li);
      chk($sformatf("rand_busy_len%0d", li), b, (lc + 2) * ((1 << lc) + WR_LAT));
      chk($sformatf("rand_done_len%0d", li), d, 1);
    end

    // reset in the middle of stage 1
    run(8, 1'b1, 300, b, d, tg);
    chk("pre_rst_wea", int'(oWE_A), 1);
    iSTART = 1'b0; iRESET = 1'b0;
    @(negedge iCLK);
    chk("rst_busy", int'(oBUSY), 0);
    chk("rst_rdy", int'(oRDY), 1);
    chk("rst_we", int'({oWE_A, oWE_B}), 0);
    chk("rst_done", int'(oDONE), 0);
    chk("rst_sd", int'(oSOURCE_DATA), 0);
    chk("rst_stage", int'(oSTAGE), 0);
    iRESET = 1'b1; exp_sd = 1'b0;
    dn = 0;
    repeat (6) begin @(negedge iCLK); dn += int'(oDONE) + int'(oBUSY); end
    chk("rst_no_done", dn, 0);

`ifdef FHT_ABORT_EN
    run(8, 1'b0, 4*259+20, b, d, tg);
    chk("pre_abort_web", int'(oWE_B), 1);
    iABORT = 1'b1;
    @(negedge iCLK);
    iABORT = 1'b0;
    chk("abort_we", int'({oWE_A, oWE_B}), 0);
    chk("abort_busy", int'(oBUSY), 0);
    chk("abort_done", int'(oDONE), 0);
    chk("aborted_pulse", int'(oABORTED), 1);
    @(negedge iCLK);
    chk("aborted_clear", int'(oABORTED), 0);
    chk("abort_no_done", int'(oDONE), 0);
    run(2, 1'b0, -1, b, d, tg);
    chk("post_abort_busy", b, 28);
    chk("post_abort_done", d, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
